// File: rtl/mac_result_drain_pkg.sv
// rtl/mac_result_drain_pkg.sv - shared widths, drain state enum and saturation limits
package mac_result_drain_pkg;

    localparam int ACCUMULATOR_WIDTH = 32;
    localparam int OUTPUT_WIDTH      = 8;

    localparam int OUT_MAX = (2 ** (OUTPUT_WIDTH - 1)) - 1;
    localparam int OUT_MIN = -(2 ** (OUTPUT_WIDTH - 1));

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } drain_state_t;

endpackage

// File: rtl/mac_result_drain_requant_lane.sv
// rtl/mac_result_drain_requant_lane.sv - one lane of requantisation: shift, optional ReLU, saturate
module requant_lane
    import mac_result_drain_pkg::*;
#(
    parameter int OUTPUT_SCALE = 0
) (
    input  logic [ACCUMULATOR_WIDTH-1:0] acc,
    input  logic                         relu_en,
    output logic [OUTPUT_WIDTH-1:0]      result
);

    localparam logic signed [ACCUMULATOR_WIDTH-1:0] SAT_MAX = ACCUMULATOR_WIDTH'(OUT_MAX);
    localparam logic signed [ACCUMULATOR_WIDTH-1:0] SAT_MIN = ACCUMULATOR_WIDTH'(OUT_MIN);

    logic signed [ACCUMULATOR_WIDTH-1:0] shifted;

    // Arithmetic shift floors toward negative infinity; no rounding is wanted.
    assign shifted = $signed(acc) >>> OUTPUT_SCALE;

    always_comb begin
        result = shifted[OUTPUT_WIDTH-1:0];
        if (relu_en && (shifted < 0)) begin
            result = '0;
        end else if (shifted > SAT_MAX) begin
            result = OUTPUT_WIDTH'(OUT_MAX);
        end else if (shifted < SAT_MIN) begin
            result = OUTPUT_WIDTH'(OUT_MIN);
        end
    end

endmodule

// File: rtl/mac_result_drain.sv
// rtl/mac_result_drain.sv - snapshots MAC accumulators and streams requantised results as LANES-wide beats
module mac_result_drain
    import mac_result_drain_pkg::*;
#(
    parameter int NUM_MACS     = 16,
    parameter int LANES        = 4,
    parameter int OUTPUT_SCALE = 0
) (
    input  logic                                  clk,
    input  logic                                  rst_in,
    input  logic                                  acc_done,
    input  logic [NUM_MACS*ACCUMULATOR_WIDTH-1:0] acc_bus,
    input  logic                                  relu_en,
    output logic                                  capture_rdy,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [LANES*OUTPUT_WIDTH-1:0]         out_data,
    output logic                                  out_last
);

    localparam int BEATS = NUM_MACS / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    drain_state_t                          state, state_n;
    logic [CNT_W-1:0]                      beat_cnt, beat_cnt_n;
    logic [NUM_MACS*ACCUMULATOR_WIDTH-1:0] snap;
    logic                                  snap_relu;

    logic                                  last_beat;
    logic                                  handshake;
    logic                                  capture;
    logic [ACCUMULATOR_WIDTH-1:0]          lane_acc [LANES];
    logic [LANES*OUTPUT_WIDTH-1:0]         lane_res;

    assign last_beat   = (beat_cnt == CNT_W'(BEATS - 1));
    assign out_valid   = (state == SEND);
    assign handshake   = out_valid && out_ready;
    // Accepting a new set on the last handshake keeps back-to-back sets bubble-free.
    assign capture_rdy = (state == IDLE) || (handshake && last_beat);
    assign capture     = acc_done && capture_rdy;
    assign out_last    = out_valid && last_beat;

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state    <= IDLE;
            beat_cnt <= '0;
        end else begin
            state    <= state_n;
            beat_cnt <= beat_cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        beat_cnt_n = beat_cnt;
        if (handshake) begin
            if (last_beat) begin
                state_n    = IDLE;
                beat_cnt_n = '0;
            end else begin
                beat_cnt_n = beat_cnt + CNT_W'(1);
            end
        end
        if (capture) begin
            state_n    = SEND;
            beat_cnt_n = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            snap_relu <= 1'b0;
        end else if (capture) begin
            snap      <= acc_bus;
            snap_relu <= relu_en;
        end
    end

    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            lane_acc[j] = snap[(int'(beat_cnt) * LANES + j) * ACCUMULATOR_WIDTH +: ACCUMULATOR_WIDTH];
        end
    end

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        requant_lane #(
            .OUTPUT_SCALE (OUTPUT_SCALE)
        ) u_requant_lane (
            .acc     (lane_acc[j]),
            .relu_en (snap_relu),
            .result  (lane_res[j*OUTPUT_WIDTH +: OUTPUT_WIDTH])
        );
    end

    // Idle output is forced to zero so stale snapshot data never leaks downstream.
    assign out_data = out_valid ? lane_res : '0;

endmodule

// File: tb/tb_mac_result_drain.sv
// tb/tb_mac_result_drain.sv - self-checking bench for mac_result_drain at scale 0 and scale 4
module tb_mac_result_drain;

    localparam int NM    = 16;
    localparam int LN    = 4;
    localparam int AW    = 32;
    localparam int OW    = 8;
    localparam int BEATS = NM / LN;

    logic            clk = 1'b0;
    logic            rst_in;
    logic            acc_done;
    logic            relu_en;
    logic            out_ready;
    logic [NM*AW-1:0] acc_bus;

    logic            cap0, val0, last0;
    logic            cap4, val4, last4;
    logic [LN*OW-1:0] data0, data4;

    always #5 clk = ~clk;

    mac_result_drain #(.NUM_MACS(NM), .LANES(LN), .OUTPUT_SCALE(0)) u_dut (
        .clk(clk), .rst_in(rst_in), .acc_done(acc_done), .acc_bus(acc_bus),
        .relu_en(relu_en), .capture_rdy(cap0), .out_valid(val0),
        .out_ready(out_ready), .out_data(data0), .out_last(last0)
    );

    mac_result_drain #(.NUM_MACS(NM), .LANES(LN), .OUTPUT_SCALE(4)) u_dut_s4 (
        .clk(clk), .rst_in(rst_in), .acc_done(acc_done), .acc_bus(acc_bus),
        .relu_en(relu_en), .capture_rdy(cap4), .out_valid(val4),
        .out_ready(out_ready), .out_data(data4), .out_last(last4)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] rq(input int acc, input int scale, input bit relu);
        int s;
        s = acc >>> scale;
        if (relu && s < 0) s = 0;
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return s[7:0];
    endfunction

    // Set-level model: a pending result set and the index of the beat on offer.
    bit m_busy = 1'b0;
    bit m_relu = 1'b0;
    int m_beat = 0;
    int m_set [NM];

    always @(posedge clk) begin
        bit fin;
        bit rdy;
        if (rst_in) begin
            m_busy = 1'b0;
            m_beat = 0;
        end else begin
            fin = m_busy && out_ready && (m_beat == BEATS - 1);
            rdy = !m_busy || fin;
            if (m_busy && out_ready) begin
                if (fin) begin
                    m_busy = 1'b0;
                    m_beat = 0;
                end else begin
                    m_beat++;
                end
            end
            if (acc_done && rdy) begin
                for (int i = 0; i < NM; i++) m_set[i] = acc_bus[i*AW +: AW];
                m_relu = relu_en;
                m_busy = 1'b1;
                m_beat = 0;
            end
        end
    end

    always @(negedge clk) begin
        logic [LN*OW-1:0] e0;
        logic [LN*OW-1:0] e4;
        e0 = '0;
        e4 = '0;
        if (m_busy) begin
            for (int j = 0; j < LN; j++) begin
                e0[j*OW +: OW] = rq(m_set[m_beat*LN + j], 0, m_relu);
                e4[j*OW +: OW] = rq(m_set[m_beat*LN + j], 4, m_relu);
            end
        end
        check("out_valid",   64'(val0),  64'(m_busy));
        check("out_last",    64'(last0), 64'(m_busy && m_beat == BEATS - 1));
        check("capture_rdy", 64'(cap0),  64'(!m_busy || (m_beat == BEATS - 1 && out_ready)));
        check("out_data",    64'(data0), 64'(e0));
        check("out_valid_s4", 64'(val4), 64'(m_busy));
        check("out_data_s4", 64'(data4), 64'(e4));
    end

    int stim [NM];

    task automatic load_bus();
        for (int i = 0; i < NM; i++) acc_bus[i*AW +: AW] = stim[i];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_index(input int base, input int mul);
        for (int i = 0; i < NM; i++) stim[i] = base + i * mul;
        load_bus();
    endtask

    initial begin
        rst_in    = 1'b1;
        acc_done  = 1'b0;
        relu_en   = 1'b0;
        out_ready = 1'b1;
        acc_bus   = '0;
        step();
        step();
        @(negedge clk);
        check("rst_out_valid",   64'(val0),  64'd0);
        check("rst_capture_rdy", 64'(cap0),  64'd1);
        check("rst_out_data",    64'(data0), 64'd0);
        step();
        rst_in = 1'b0;
        step();

        // Index pattern, full throughput
        fill_index(0, 1);
        acc_done = 1'b1;
        step();
        acc_done = 1'b0;
        @(negedge clk);
        check("idx_beat0", 64'(data0), 64'h03020100);
        check("idx_beat0_last", 64'(last0), 64'd0);
        step(); step(); step();
        @(negedge clk);
        check("idx_beat3", 64'(data0), 64'h0F0E0D0C);
        check("idx_beat3_last", 64'(last0), 64'd1);
        step(); step();

        // Saturation and scale-4 floor
        fill_index(0, 1);
        stim[0] = 300;  stim[1] = -300; stim[2] = 127; stim[3] = -128;
        stim[4] = -17;  stim[5] = 40;   stim[6] = 0;   stim[7] = -1;
        load_bus();
        acc_done = 1'b1;
        step();
        acc_done = 1'b0;
        @(negedge clk);
        check("sat_beat0",    64'(data0), 64'h807F807F);
        check("sat_beat0_s4", 64'(data4), 64'hF807ED12);
        step();
        @(negedge clk);
        check("sat_beat1",    64'(data0), 64'hFF0028EF);
        check("sat_beat1_s4", 64'(data4), 64'hFF0002FE);
        step(); step(); step();

        // ReLU, flag dropped after capture
        fill_index(-8, 1);
        stim[0] = -5; stim[1] = 0; stim[2] = 5; stim[3] = -1000;
        load_bus();
        relu_en  = 1'b1;
        acc_done = 1'b1;
        step();
        acc_done = 1'b0;
        relu_en  = 1'b0;
        @(negedge clk);
        check("relu_beat0", 64'(data0), 64'h00050000);
        step();
        @(negedge clk);
        check("relu_beat1_held_flag", 64'(data0), 64'h00000000);
        step(); step(); step();

        // Backpressure on beat 1
        fill_index(0, 3);
        acc_done = 1'b1;
        step();
        acc_done = 1'b0;
        step();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_data", 64'(data0), 64'h15120F0C);
            check("stall_last", 64'(last0), 64'd0);
            step();
        end
        out_ready = 1'b1;
        step(); step(); step(); step();

        // Back-to-back capture on the last-beat handshake
        fill_index(0, 1);
        acc_done = 1'b1;
        step();
        acc_done = 1'b0;
        step(); step(); step();
        fill_index(100, 1);
        acc_done = 1'b1;
        step();
        acc_done = 1'b0;
        @(negedge clk);
        check("b2b_valid", 64'(val0),  64'd1);
        check("b2b_beat0", 64'(data0), 64'h67666564);
        step(); step(); step(); step(); step();

        // acc_done mid-SEND is ignored
        fill_index(0, 1);
        acc_done = 1'b1;
        step();
        acc_done = 1'b0;
        step();
        fill_index(100, 1);
        acc_done = 1'b1;
        step(); step();
        acc_done = 1'b0;
        @(negedge clk);
        check("ignore_beat3", 64'(data0), 64'h0F0E0D0C);
        step(); step(); step();

        // Reset mid-SEND
        fill_index(0, 1);
        acc_done = 1'b1;
        step();
        acc_done = 1'b0;
        step();
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", 64'(val0), 64'd0);
        step(); step(); step();
        @(negedge clk);
        check("rst_mid_quiet", 64'(val0), 64'd0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
